// File: rtl/ram_arb_pkg.sv
// Shared state encoding, owner codes and default widths for the RAM arbiter.
package ram_arb_pkg;

   localparam int DEF_ADDR_W = 9;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } arb_state_t;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Request/acknowledge bundle for the two RAM requesters (CPU and DMA).
interface ram_arbiter_if
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ack;

   logic              dma_req;
   logic              dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic [DATA_W-1:0] dma_rdata;
   logic              dma_ack;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ack,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_rdata, dma_ack
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ack,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_rdata, dma_ack
   );

endinterface

// File: rtl/arb_burst_counter.sv
// Counts consecutive CPU grants made while DMA is waiting; flags when the limit is reached.
module arb_burst_counter #(
   parameter int MAX_BURST = 4
)(
   input  logic clk,
   input  logic rst,
   input  logic i_cpu_grant,
   input  logic i_clear,
   output logic o_at_limit
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   logic [CNT_W-1:0] r_count;

   assign o_at_limit = (r_count == CNT_W'(MAX_BURST));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_cpu_grant && !o_at_limit) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between CPU and DMA requesters with read-latency sequencing.
// Define RAM_ARB_FAIR_EN to bound DMA starvation to MAX_BURST consecutive CPU grants.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int RD_LAT    = 1,
   parameter int MAX_BURST = 4
)(
   input  logic              clk,
   input  logic              rst,
   ram_arbiter_if.slave      bus,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              owner,
   output logic              busy
);

   localparam int LAT_W = 2;

   if (RD_LAT < 1 || RD_LAT > 3 || MAX_BURST < 1) begin : g_param_check
      $error("ram_arbiter: RD_LAT must be 1..3 and MAX_BURST at least 1");
   end

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   logic [LAT_W-1:0]  r_lat_cnt;
   logic              r_owner;
   logic              r_ram_we;
   logic [ADDR_W-1:0] r_ram_addr;
   logic [DATA_W-1:0] r_ram_wdata;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic [DATA_W-1:0] r_dma_rdata;

   logic w_idle;
   logic w_any_req;
   logic w_grant_dma;
   logic w_fair_fire;
   logic w_lat_done;

   assign w_idle      = (r_state == IDLE);
   assign w_any_req   = bus.cpu_req | bus.dma_req;
   assign w_grant_dma = bus.dma_req & (~bus.cpu_req | w_fair_fire);
   assign w_lat_done  = (r_lat_cnt == LAT_W'(RD_LAT - 1));

`ifdef RAM_ARB_FAIR_EN
   logic w_burst_limit;

   // A CPU grant with dma_req high is exactly an IDLE cycle where DMA asks but loses.
   arb_burst_counter #(.MAX_BURST(MAX_BURST)) u_burst (
      .clk         (clk),
      .rst         (rst),
      .i_cpu_grant (w_idle & bus.dma_req & ~w_grant_dma),
      .i_clear     (w_idle & (~bus.dma_req | w_grant_dma)),
      .o_at_limit  (w_burst_limit)
   );

   assign w_fair_fire = w_burst_limit & bus.dma_req;
`else
   assign w_fair_fire = 1'b0;
`endif

   // NOTE: every variable assigned in a combinational block gets a default first, so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_any_req) w_state_nxt = ACCESS;
         ACCESS:  w_state_nxt = r_ram_we ? DONE : WAIT;
         WAIT:    if (w_lat_done) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_owner     <= OWN_CPU;
         r_ram_we    <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_lat_cnt   <= '0;
         r_cpu_rdata <= '0;
         r_dma_rdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_owner <= w_grant_dma ? OWN_DMA : OWN_CPU;
                  if (w_grant_dma) begin
                     r_ram_we    <= bus.dma_we;
                     r_ram_addr  <= bus.dma_addr;
                     r_ram_wdata <= bus.dma_wdata;
                  end else begin
                     r_ram_we    <= bus.cpu_we;
                     r_ram_addr  <= bus.cpu_addr;
                     r_ram_wdata <= bus.cpu_wdata;
                  end
               end
            end
            ACCESS: begin
               r_ram_we  <= 1'b0;
               r_lat_cnt <= '0;
            end
            WAIT: begin
               if (w_lat_done) begin
                  if (r_owner == OWN_DMA) r_dma_rdata <= ram_rdata;
                  else                    r_cpu_rdata <= ram_rdata;
               end else begin
                  r_lat_cnt <= r_lat_cnt + LAT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign ram_we        = r_ram_we;
   assign ram_addr      = r_ram_addr;
   assign ram_wdata     = r_ram_wdata;
   assign owner         = r_owner;
   assign busy          = ~w_idle;
   assign bus.cpu_rdata = r_cpu_rdata;
   assign bus.dma_rdata = r_dma_rdata;
   assign bus.cpu_ack   = (r_state == DONE) && (r_owner == OWN_CPU);
   assign bus.dma_ack   = (r_state == DONE) && (r_owner == OWN_DMA);

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed CPU/DMA transactions against a behavioural RAM.
module tb_ram_arbiter;

   localparam int ADDR_W    = 9;
   localparam int DATA_W    = 32;
   localparam int RD_LAT    = 1;
   localparam int MAX_BURST = 4;
   localparam int WR_LAT    = 2;
   localparam int RDL       = 2 + RD_LAT;

   typedef struct {
      int          cyc;
      bit          chk_data;
      logic [31:0] data;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_we;
   logic [DATA_W-1:0] ram_rdata;
   logic              owner;
   logic              busy;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   dma_ack_cnt = 0;
   exp_t cpu_q[$];
   exp_t dma_q[$];

   logic [DATA_W-1:0] mem [512];
   logic [DATA_W-1:0] rd_pipe [RD_LAT];

   ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   ram_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we),
      .ram_rdata (ram_rdata),
      .owner     (owner),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Behavioural RAM with RD_LAT cycles of synchronous read latency.
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      rd_pipe[0] <= mem[ram_addr];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign ram_rdata = rd_pipe[RD_LAT-1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name, input string why);
      n_cmp++;
      n_err++;
      $display("FAIL %s: %s (cycle %0d)", name, why, cyc);
   endtask

   task automatic score(input bit is_dma, input logic [31:0] rdata);
      exp_t e;
      string p = is_dma ? "dma" : "cpu";
      check({p, "_ack_owner"}, 32'(owner), 32'(is_dma));
      check({p, "_ack_busy"}, 32'(busy), 32'd1);
      if ((is_dma && dma_q.size() == 0) || (!is_dma && cpu_q.size() == 0)) begin
         fail({p, "_ack_unexpected"}, "ack with no transaction outstanding");
         return;
      end
      if (is_dma) e = dma_q.pop_front();
      else        e = cpu_q.pop_front();
      check({p, "_ack_cycle"}, 32'(cyc), 32'(e.cyc));
      if (e.chk_data) check({p, "_rdata"}, rdata, e.data);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (bus.cpu_ack) score(1'b0, bus.cpu_rdata);
         if (bus.dma_ack) begin
            dma_ack_cnt++;
            score(1'b1, bus.dma_rdata);
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ram_we"},    32'(ram_we), 32'd0);
      check({tag, "_ram_addr"},  32'(ram_addr), 32'd0);
      check({tag, "_ram_wdata"}, ram_wdata, 32'd0);
      check({tag, "_cpu_ack"},   32'(bus.cpu_ack), 32'd0);
      check({tag, "_dma_ack"},   32'(bus.dma_ack), 32'd0);
      check({tag, "_cpu_rdata"}, bus.cpu_rdata, 32'd0);
      check({tag, "_dma_rdata"}, bus.dma_rdata, 32'd0);
      check({tag, "_owner"},     32'(owner), 32'd0);
      check({tag, "_busy"},      32'(busy), 32'd0);
   endtask

   task automatic wait_ack(input bit is_dma, input string name);
      bit got = 1'b0;
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clk);
         got = is_dma ? bus.dma_ack : bus.cpu_ack;
      end
      if (!got) fail(name, "no ack within 64 cycles");
   endtask

   // Raises req in an IDLE cycle n; expects the ack in cycle n+lat.
   task automatic txn(input bit is_dma, input bit we, input logic [8:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_data, input int lat);
      @(negedge clk);
      if (is_dma) begin
         bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wdata;
         dma_q.push_back('{cyc + lat, !we, exp_data});
      end else begin
         bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
         cpu_q.push_back('{cyc + lat, !we, exp_data});
      end
      wait_ack(is_dma, is_dma ? "dma_txn_timeout" : "cpu_txn_timeout");
      if (is_dma) bus.dma_req = 1'b0;
      else        bus.cpu_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int slots;
      int dma_before;

      for (int i = 0; i < 512; i++) mem[i] = 32'h0;
      mem[0] = 32'h1234_5678;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b1;

      // CPU write 0xDEADBEEF to 0x1A5 with cycle-accurate RAM-side checks.
      @(negedge clk);
      n = cyc;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 9'h1A5; bus.cpu_wdata = 32'hDEAD_BEEF;
      cpu_q.push_back('{n + WR_LAT, 1'b0, 32'h0});
      @(negedge clk);
      check("wr_ram_we_n1", 32'(ram_we), 32'd1);
      check("wr_ram_addr_n1", 32'(ram_addr), 32'h1A5);
      check("wr_ram_wdata_n1", ram_wdata, 32'hDEAD_BEEF);
      check("wr_busy_n1", 32'(busy), 32'd1);
      wait_ack(1'b0, "cpu_wr_timeout");
      check("wr_ram_we_n2", 32'(ram_we), 32'd0);
      check("wr_mem_1a5", mem[9'h1A5], 32'hDEAD_BEEF);
      bus.cpu_req = 1'b0;

      txn(1'b0, 1'b0, 9'h1A5, 32'h0, 32'hDEAD_BEEF, RDL);
      check("rd_dma_rdata_untouched", bus.dma_rdata, 32'd0);

      // Simultaneous writes: DMA acked 3 cycles after CPU.
      fork
         txn(1'b0, 1'b1, 9'h010, 32'h1111_1111, 32'h0, WR_LAT);
         txn(1'b1, 1'b1, 9'h020, 32'h2222_2222, 32'h0, WR_LAT + 3);
      join
      // Simultaneous reads: DMA acked 3+RD_LAT cycles after CPU.
      fork
         txn(1'b0, 1'b0, 9'h020, 32'h0, 32'h2222_2222, RDL);
         txn(1'b1, 1'b0, 9'h010, 32'h0, 32'h1111_1111, RDL + 3 + RD_LAT);
      join
      check("sim_cpu_rdata_kept", bus.cpu_rdata, 32'h2222_2222);
      check("sim_owner_dma", 32'(owner), 32'd1);

      txn(1'b1, 1'b0, 9'h000, 32'h0, 32'h1234_5678, RDL);

      // Back-to-back DMA reads with req held across the first ack.
      @(negedge clk);
      n = cyc;
      bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 9'h1A5;
      dma_q.push_back('{n + RDL, 1'b1, 32'hDEAD_BEEF});
      dma_q.push_back('{n + 2 * RDL + 1, 1'b1, 32'h1111_1111});
      wait_ack(1'b1, "b2b_first_timeout");
      bus.dma_addr = 9'h010;
      wait_ack(1'b1, "b2b_second_timeout");
      bus.dma_req = 1'b0;
      repeat (4) @(negedge clk);

      // Both requesters write continuously; each transaction takes 3 cycles.
      @(negedge clk);
      n = cyc;
      dma_before = dma_ack_cnt;
`ifdef RAM_ARB_FAIR_EN
      slots = 3 * (MAX_BURST + 1);
`else
      slots = 34;
`endif
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 9'h100; bus.cpu_wdata = 32'hA5A5_0001;
      bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 9'h101; bus.dma_wdata = 32'h5A5A_0002;
      for (int i = 0; i < slots; i++) begin
`ifdef RAM_ARB_FAIR_EN
         if (i % (MAX_BURST + 1) == MAX_BURST) dma_q.push_back('{n + WR_LAT + 3 * i, 1'b0, 32'h0});
         else                                  cpu_q.push_back('{n + WR_LAT + 3 * i, 1'b0, 32'h0});
`else
         cpu_q.push_back('{n + WR_LAT + 3 * i, 1'b0, 32'h0});
`endif
      end
      repeat (WR_LAT + 3 * (slots - 1)) @(negedge clk);
      bus.cpu_req = 1'b0;
      bus.dma_req = 1'b0;
`ifdef RAM_ARB_FAIR_EN
      check("fair_dma_grants", 32'(dma_ack_cnt - dma_before), 32'd3);
`else
      check("starve_dma_grants", 32'(dma_ack_cnt - dma_before), 32'd0);
`endif
      repeat (4) @(negedge clk);

      // Reset during ACCESS of a CPU write: write dropped, no ack, outputs cleared at once.
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 9'h1A5; bus.cpu_wdata = 32'hCAFE_F00D;
      @(negedge clk);
      check("rst_mid_we_before", 32'(ram_we), 32'd1);
      rst = 1'b0;
      bus.cpu_req = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      repeat (3) @(negedge clk);
      check("rst_mid_mem_kept", mem[9'h1A5], 32'hDEAD_BEEF);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("post_rst");
      txn(1'b0, 1'b0, 9'h1A5, 32'h0, 32'hDEAD_BEEF, RDL);

      repeat (5) @(negedge clk);
      check("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
      check("dma_queue_drained", 32'(dma_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
